// File: rtl/zaxdma_lfsr_master.sv
// zaxdma_lfsr_master: AXI4 burst master that writes a 32-bit LFSR byte stream
// into a slave, or reads a burst back and checks it against the same stream.
// One burst per i_start; o_done pulses on completion and o_err is sticky.
module zaxdma_lfsr_master #(
  parameter int unsigned ADDRESS_WIDTH = 30,
  parameter int unsigned BUS_WIDTH     = 64,
  parameter int unsigned IW            = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  // Command port
  input  logic                       i_start,
  input  logic                       i_dir,
  input  logic [ADDRESS_WIDTH-1:0]   i_addr,
  input  logic [7:0]                 i_len,
  input  logic [31:0]                i_seed,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err,
  // Write address channel
  output logic                       M_AXI_AWVALID,
  input  logic                       M_AXI_AWREADY,
  output logic [IW-1:0]              M_AXI_AWID,
  output logic [ADDRESS_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                 M_AXI_AWLEN,
  output logic [2:0]                 M_AXI_AWSIZE,
  output logic [1:0]                 M_AXI_AWBURST,
  output logic                       M_AXI_AWLOCK,
  output logic [3:0]                 M_AXI_AWCACHE,
  output logic [2:0]                 M_AXI_AWPROT,
  output logic [3:0]                 M_AXI_AWQOS,
  // Write data channel
  output logic                       M_AXI_WVALID,
  input  logic                       M_AXI_WREADY,
  output logic [BUS_WIDTH-1:0]       M_AXI_WDATA,
  output logic [BUS_WIDTH/8-1:0]     M_AXI_WSTRB,
  output logic                       M_AXI_WLAST,
  // Write response channel
  input  logic                       M_AXI_BVALID,
  output logic                       M_AXI_BREADY,
  input  logic [IW-1:0]              M_AXI_BID,
  input  logic [1:0]                 M_AXI_BRESP,
  // Read address channel
  output logic                       M_AXI_ARVALID,
  input  logic                       M_AXI_ARREADY,
  output logic [IW-1:0]              M_AXI_ARID,
  output logic [ADDRESS_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                 M_AXI_ARLEN,
  output logic [2:0]                 M_AXI_ARSIZE,
  output logic [1:0]                 M_AXI_ARBURST,
  output logic                       M_AXI_ARLOCK,
  output logic [3:0]                 M_AXI_ARCACHE,
  output logic [2:0]                 M_AXI_ARPROT,
  output logic [3:0]                 M_AXI_ARQOS,
  // Read data channel
  input  logic                       M_AXI_RVALID,
  output logic                       M_AXI_RREADY,
  input  logic [IW-1:0]              M_AXI_RID,
  input  logic [BUS_WIDTH-1:0]       M_AXI_RDATA,
  input  logic                       M_AXI_RLAST,
  input  logic [1:0]                 M_AXI_RRESP
);

  localparam int unsigned NW   = BUS_WIDTH / 32;
  localparam int unsigned LSB  = $clog2(BUS_WIDTH / 8);
  localparam logic [31:0] POLY = 32'hc000_0000;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_DONE
  } state_t;

  state_t                     r_state, w_next;
  logic [ADDRESS_WIDTH-1:0]   r_addr;
  logic [7:0]                 r_len;
  logic [31:0]                r_lfsr;
  logic [8:0]                 r_beat;
  logic                       r_aw_done, r_w_done, r_b_done, r_err;

  logic [BUS_WIDTH-1:0]       w_beat;
  logic [31:0]                w_next_lfsr;
  logic [31:0]                w_tmp;
  logic                       w_last, w_aw_hs, w_w_hs, w_r_hs;
  logic                       w_aw_fin, w_w_fin, w_rd_bad;
  logic                       w_unused;

  function automatic logic [31:0] f_advance(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int unsigned i = 0; i < 32; i++)
      t = {t[30:0], ^(t & POLY)};
    return t;
  endfunction

  // Expand the current LFSR state into one bus beat and the state after it
  always_comb begin
    w_beat = '0;
    w_tmp  = r_lfsr;
    for (int unsigned k = 0; k < NW; k++) begin
      w_beat[32*k +: 32] = w_tmp;
      w_tmp = f_advance(w_tmp);
    end
    w_next_lfsr = w_tmp;
  end

  assign w_last   = (r_beat == {1'b0, r_len});
  assign w_aw_hs  = M_AXI_AWVALID && M_AXI_AWREADY;
  assign w_w_hs   = M_AXI_WVALID && M_AXI_WREADY;
  assign w_r_hs   = M_AXI_RVALID && M_AXI_RREADY;
  assign w_aw_fin = r_aw_done || w_aw_hs;
  assign w_w_fin  = r_w_done || (w_w_hs && w_last);
  assign w_rd_bad = (M_AXI_RDATA != w_beat) || (M_AXI_RRESP != 2'b00)
                 || (M_AXI_RLAST != w_last);
  assign w_unused = ^{M_AXI_BID, M_AXI_RID, i_addr[LSB-1:0]};

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state selection
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = i_dir ? S_RADDR : S_WRITE;
      S_WRITE: if (w_aw_fin && w_w_fin) w_next = S_WRESP;
      // The response is registered first, so DONE follows one cycle later
      S_WRESP: if (r_b_done) w_next = S_DONE;
      S_RADDR: if (M_AXI_ARREADY) w_next = S_RDATA;
      S_RDATA: if (w_r_hs && w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Channel handshake and status outputs decoded from state
  always_comb begin
    o_busy        = (r_state != S_IDLE);
    o_done        = (r_state == S_DONE);
    M_AXI_AWVALID = (r_state == S_WRITE) && !r_aw_done;
    M_AXI_WVALID  = (r_state == S_WRITE) && !r_w_done;
    M_AXI_WLAST   = (r_state == S_WRITE) && w_last;
    M_AXI_BREADY  = (r_state == S_WRESP) && !r_b_done;
    M_AXI_ARVALID = (r_state == S_RADDR);
    M_AXI_RREADY  = (r_state == S_RDATA);
  end

  // Command capture, beat counting, LFSR stepping and error tracking
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr    <= '0;
      r_len     <= '0;
      r_lfsr    <= '0;
      r_beat    <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_b_done  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_addr    <= {i_addr[ADDRESS_WIDTH-1:LSB], {LSB{1'b0}}};
          r_len     <= i_len;
          r_lfsr    <= i_seed;
          r_beat    <= '0;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
          r_b_done  <= 1'b0;
          r_err     <= 1'b0;
        end
        S_WRITE: begin
          if (w_aw_hs) r_aw_done <= 1'b1;
          if (w_w_hs) begin
            r_lfsr <= w_next_lfsr;
            r_beat <= r_beat + 9'd1;
            if (w_last) r_w_done <= 1'b1;
          end
        end
        S_WRESP: if (M_AXI_BVALID && !r_b_done) begin
          r_b_done <= 1'b1;
          if (M_AXI_BRESP != 2'b00) r_err <= 1'b1;
        end
        S_RDATA: if (w_r_hs) begin
          r_lfsr <= w_next_lfsr;
          r_beat <= r_beat + 9'd1;
          if (w_rd_bad) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_err         = r_err;

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = r_len;
  assign M_AXI_AWSIZE  = 3'(LSB);
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = '0;
  assign M_AXI_AWPROT  = '0;
  assign M_AXI_AWQOS   = '0;

  assign M_AXI_WDATA   = w_beat;
  assign M_AXI_WSTRB   = '1;

  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARLEN   = r_len;
  assign M_AXI_ARSIZE  = 3'(LSB);
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = '0;
  assign M_AXI_ARPROT  = '0;
  assign M_AXI_ARQOS   = '0;

endmodule

// File: tb/tb_zaxdma_lfsr_master.sv
// Bench for zaxdma_lfsr_master: negedge-driven AXI slave/LFSR responder plus
// directed command sequences with hand-derived expectations.
module tb_zaxdma_lfsr_master;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic i_reset, i_start, i_dir;
  logic [AW-1:0] i_addr;
  logic [7:0] i_len;
  logic [31:0] i_seed;
  logic o_busy, o_done, o_err;
  logic awvalid, awready, awlock, wvalid, wready, wlast, bvalid, bready;
  logic arvalid, arready, arlock, rvalid, rready, rlast;
  logic [0:0] awid, bid, arid, rid;
  logic [AW-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic [3:0] awcache, awqos, arcache, arqos;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;

  zaxdma_lfsr_master #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .IW(1)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_start(i_start), .i_dir(i_dir),
    .i_addr(i_addr), .i_len(i_len), .i_seed(i_seed),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWID(awid),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata),
    .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BID(bid),
    .M_AXI_BRESP(bresp),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARID(arid),
    .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RID(rid),
    .M_AXI_RDATA(rdata), .M_AXI_RLAST(rlast), .M_AXI_RRESP(rresp)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [63:0] got,
                           input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference LFSR: 32 shifts, feedback = bit31 ^ bit30
  function automatic logic [31:0] adv(input logic [31:0] s);
    for (int i = 0; i < 32; i++) s = {s[30:0], s[31] ^ s[30]};
    return s;
  endfunction

  function automatic logic [63:0] exp_beat(input logic [31:0] seed, input int k);
    logic [31:0] st;
    st = seed;
    for (int j = 0; j < k; j++) st = adv(adv(st));
    return {adv(st), st};
  endfunction

  // Slave knobs and captures
  bit          bp = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  int          flip_beat = -1;
  logic [31:0] r_seed = 32'd0;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, stab_bad, b_cyc, r_last_cyc;
  logic [AW-1:0] cap_awaddr, cap_araddr;
  logic [7:0]    cap_awlen;
  logic [63:0]   w_cap [0:15];
  logic [15:0]   w_lastcap;
  bit aw_done_s, wl_done_s, b_issued;

  // Slave process: all state changes on negedge, handshakes land on the next posedge
  initial begin
    bit aw_hs, w_hs, w_hs_last, b_hs, ar_hs, r_hs;
    bit st_aw, st_w, st_ar;
    logic [AW-1:0] sv_awaddr, sv_araddr;
    logic [63:0] sv_wdata;
    logic sv_wlast;
    int r_left, r_idx;
    logic [7:0] r_len_s;
    logic [31:0] r_st;
    aw_hs = 0; w_hs = 0; w_hs_last = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
    st_aw = 0; st_w = 0; st_ar = 0; r_left = 0; r_idx = 0; r_len_s = 0; r_st = 0;
    sv_awaddr = '0; sv_araddr = '0; sv_wdata = '0; sv_wlast = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    arready = 0; rvalid = 0; rdata = '0; rlast = 0; rresp = 0; rid = 0;
    forever begin
      @(negedge clk);
      if (i_reset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rlast = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        st_aw = 0; st_w = 0; st_ar = 0; r_left = 0;
        continue;
      end
      if (st_aw && (!awvalid || awaddr != sv_awaddr)) stab_bad++;
      if (st_w && (!wvalid || wdata != sv_wdata || wlast != sv_wlast)) stab_bad++;
      if (st_ar && (!arvalid || araddr != sv_araddr)) stab_bad++;
      if (aw_hs) aw_done_s = 1;
      if (w_hs && w_hs_last) wl_done_s = 1;
      if (b_hs) bvalid = 0;
      if (ar_hs) begin r_left = int'(r_len_s) + 1; r_idx = 0; r_st = r_seed; end
      if (r_hs) begin rvalid = 0; r_idx++; r_left--; r_st = adv(adv(r_st)); end
      if (aw_done_s && wl_done_s && !b_issued) begin
        bvalid = 1; bresp = bresp_cfg; b_issued = 1;
      end
      if (!rvalid && r_left > 0 && (!bp || $urandom_range(0, 1) == 1)) begin
        rvalid = 1;
        rdata  = {adv(r_st), r_st};
        if (r_idx == flip_beat) rdata[0] = ~rdata[0];
        rlast  = (r_idx == int'(r_len_s));
        rresp  = 2'b00;
      end
      awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      aw_hs = awvalid && awready;
      if (aw_hs) begin aw_cnt++; cap_awaddr = awaddr; cap_awlen = awlen; end
      w_hs = wvalid && wready;
      w_hs_last = wlast;
      if (w_hs) begin
        if (w_cnt < 16) begin w_cap[w_cnt] = wdata; w_lastcap[w_cnt] = wlast; end
        w_cnt++;
      end
      b_hs = bvalid && bready;
      if (b_hs) begin b_cnt++; b_cyc = cyc; end
      ar_hs = arvalid && arready;
      if (ar_hs) begin ar_cnt++; cap_araddr = araddr; r_len_s = arlen; end
      r_hs = rvalid && rready;
      if (r_hs) begin r_cnt++; r_last_cyc = cyc; end
      st_aw = awvalid && !awready; sv_awaddr = awaddr;
      st_w  = wvalid && !wready;   sv_wdata = wdata; sv_wlast = wlast;
      st_ar = arvalid && !arready; sv_araddr = araddr;
    end
  end

  task automatic clear_caps();
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0; stab_bad = 0;
    b_cyc = 0; r_last_cyc = 0; w_lastcap = '0;
    aw_done_s = 0; wl_done_s = 0; b_issued = 0;
    for (int i = 0; i < 16; i++) w_cap[i] = '0;
  endtask

  task automatic start_txn(input bit dir, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [31:0] seed);
    clear_caps();
    @(negedge clk);
    i_dir = dir; i_addr = addr; i_len = len; i_seed = seed; i_start = 1;
    @(negedge clk);
    i_start = 0;
    check_val("busy_after_start", {63'd0, o_busy}, 64'd1);
    if (dir) check_val("arvalid_after_start", {63'd0, arvalid}, 64'd1);
    else     check_val("awwvalid_after_start", {62'd0, awvalid, wvalid}, 64'd3);
  endtask

  task automatic wait_done(output int dc);
    int n;
    n = 0;
    while (!o_done && n < 3000) begin @(negedge clk); n++; end
    check_val("done_seen", {63'd0, o_done}, 64'd1);
    dc = cyc;
    #1;
  endtask

  task automatic check_pulse_end();
    @(negedge clk);
    check_val("done_one_cycle", {62'd0, o_done, o_busy}, 64'd0);
  endtask

  initial begin
    int dc, n;
    i_reset = 1; i_start = 0; i_dir = 0; i_addr = '0; i_len = '0; i_seed = '0;
    clear_caps();
    repeat (3) @(negedge clk);
    check_val("reset_outputs",
              {56'd0, o_busy, o_done, o_err, awvalid, wvalid, arvalid, bready, rready},
              64'd0);
    i_reset = 0;

    // Write, seed 1, four beats, zero-wait slave
    start_txn(1'b0, 30'h100, 8'd3, 32'd1);
    wait_done(dc);
    check_val("w_awaddr", 64'(cap_awaddr), 64'h100);
    check_val("w_awlen", 64'(cap_awlen), 64'd3);
    check_val("w_attr", {49'd0, awsize, awburst, wstrb, awid}, {49'd0, 3'd3, 2'b01, 8'hff, 1'b0});
    check_val("w_beats", 64'(w_cnt), 64'd4);
    check_val("w_beat0", w_cap[0], 64'h00000003_00000001);
    check_val("w_beat1_lo", {32'd0, w_cap[1][31:0]}, 64'h5);
    for (int k = 0; k < 4; k++) check_val("w_data", w_cap[k], exp_beat(32'd1, k));
    check_val("w_wlast_pat", {48'd0, w_lastcap}, 64'h8);
    check_val("w_done_lat", 64'(dc - b_cyc), 64'd2);
    check_val("w_err", {63'd0, o_err}, 64'd0);
    check_pulse_end();

    // Read-back against the responder, seed 1
    r_seed = 32'd1; flip_beat = -1;
    start_txn(1'b1, 30'h100, 8'd3, 32'd1);
    wait_done(dc);
    check_val("r_araddr", 64'(cap_araddr), 64'h100);
    check_val("r_beats", 64'(r_cnt), 64'd4);
    check_val("r_done_lat", 64'(dc - r_last_cyc), 64'd1);
    check_val("r_err", {63'd0, o_err}, 64'd0);
    check_pulse_end();

    // Read mismatch: bit 0 of beat 2 flipped
    flip_beat = 2;
    start_txn(1'b1, 30'h100, 8'd3, 32'd1);
    wait_done(dc);
    check_val("rm_err_at_done", {63'd0, o_err}, 64'd1);
    check_val("rm_beats", 64'(r_cnt), 64'd4);
    repeat (5) @(negedge clk);
    check_val("rm_err_sticky", {63'd0, o_err}, 64'd1);
    flip_beat = -1;

    // Single beat write with SLVERR; the new start clears the sticky error
    bresp_cfg = 2'b10;
    start_txn(1'b0, 30'h47, 8'd0, 32'h1234_5678);
    check_val("err_cleared_on_start", {63'd0, o_err}, 64'd0);
    wait_done(dc);
    check_val("se_awaddr_aligned", 64'(cap_awaddr), 64'h40);
    check_val("se_awlen", 64'(cap_awlen), 64'd0);
    check_val("se_beats", 64'(w_cnt), 64'd1);
    check_val("se_wlast", {63'd0, w_lastcap[0]}, 64'd1);
    check_val("se_data", w_cap[0], exp_beat(32'h1234_5678, 0));
    check_val("se_err", {63'd0, o_err}, 64'd1);
    bresp_cfg = 2'b00;

    // Backpressure: random stalls on every ready and on RVALID
    bp = 1;
    start_txn(1'b0, 30'h200, 8'd7, 32'd1);
    wait_done(dc);
    check_val("bp_w_beats", 64'(w_cnt), 64'd8);
    for (int k = 0; k < 8; k++) check_val("bp_w_data", w_cap[k], exp_beat(32'd1, k));
    check_val("bp_w_wlast_pat", {48'd0, w_lastcap}, 64'h80);
    check_val("bp_w_stable", 64'(stab_bad), 64'd0);
    check_val("bp_w_err", {63'd0, o_err}, 64'd0);
    start_txn(1'b1, 30'h200, 8'd7, 32'd1);
    wait_done(dc);
    check_val("bp_r_beats", 64'(r_cnt), 64'd8);
    check_val("bp_r_stable", 64'(stab_bad), 64'd0);
    check_val("bp_r_err", {63'd0, o_err}, 64'd0);
    bp = 0;

    // i_start while busy and in the DONE cycle is ignored
    start_txn(1'b0, 30'h300, 8'd3, 32'd5);
    i_addr = 30'h380; i_start = 1;
    @(negedge clk);
    i_start = 0;
    wait_done(dc);
    i_addr = 30'h3c0; i_start = 1;
    @(negedge clk);
    i_start = 0;
    check_val("ctl_idle_after_done", {63'd0, o_busy}, 64'd0);
    repeat (3) @(negedge clk);
    check_val("ctl_single_aw", 64'(aw_cnt), 64'd1);
    check_val("ctl_awaddr", 64'(cap_awaddr), 64'h300);

    // Reset during beat 2
    start_txn(1'b0, 30'h400, 8'd7, 32'd9);
    n = 0;
    while (w_cnt < 2 && n < 200) begin @(negedge clk); #1; n++; end
    check_val("rst_reached_beat2", 64'(w_cnt), 64'd2);
    i_reset = 1;
    @(negedge clk);
    check_val("rst_midburst",
              {56'd0, o_busy, o_done, o_err, awvalid, wvalid, arvalid, bready, rready},
              64'd0);
    i_reset = 0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
